// File: rtl/aes_pkg.sv
// Shared AES types and constants for the cipher controllers and datapath.
package aes_pkg;

    typedef logic [31:0] aes_32;

    // Encodings 3'd5..3'd7 are undefined and decode as NOOP.
    typedef enum logic [2:0] {
        NOOP       = 3'd0,
        AESDEC     = 3'd1,
        AESDECLAST = 3'd2,
        AESDECFULL = 3'd3,
        AESIMC     = 3'd4
    } opcode;

    localparam logic [7:0] RCON_FIRST = 8'h01;
    localparam logic [7:0] RCON_LAST  = 8'h36;
    localparam int         NR_128     = 10;

    typedef enum logic [2:0] {
        IDLE, KEY_SUB, KEY_GEN, INIT, INV_SBOX, ROUND, FINISH
    } dec_state_e;

    typedef struct packed {
        logic data_sub;
        logic first_rnd;
        logic inv_mix;
        logic imc;
        logic key_sel;
        logic en_rnd;
        logic en_key;
        logic key_sub;
        logic gen_key;
        logic inv_key;
        logic plain_ready;
        logic busy;
    } dec_ctrl_t;

endpackage

// File: rtl/aes_rcon_step.sv
// One step of the round-constant sequence: GF(2^8) doubling forward, its inverse backward.
module aes_rcon_step (
    input  logic [7:0] rcon_i,
    input  logic       inv_i,
    output logic [7:0] rcon_o
);

    always_comb begin
        rcon_o = '0;
        if (inv_i) begin
            rcon_o = (rcon_i == 8'h1b) ? 8'h80 : (rcon_i >> 1);
        end else begin
            rcon_o = rcon_i[7] ? ((rcon_i << 1) ^ 8'h1b) : (rcon_i << 1);
        end
    end

endmodule

// File: rtl/aes_dec_ctrl.sv
// Sequencer for the AES-128 inverse-cipher datapath and key_gen block.
module aes_dec_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start_i,
    input  opcode       opcode_i,
    output logic        data_sub_o,
    output logic        first_rnd_o,
    output logic        inv_mix_o,
    output logic        imc_o,
    output logic        key_sel_o,
    output logic        en_rnd_o,
    output logic        en_key_o,
    output logic        key_sub_o,
    output logic        gen_key_o,
    output logic        inv_key_o,
    output logic [3:0]  rnd_num_o,
    output aes_32       r_con_ctrl_o,
    output logic        plain_ready_o,
    output logic        busy_o
);

    localparam logic [3:0] RND_LAST_FWD = 4'(NR - 1);

    dec_state_e state_q, state_d;
    opcode      op_q, op_d;
    logic [3:0] rnd_q, rnd_d;
    logic [7:0] rcon_q, rcon_d;
    logic [7:0] rcon_step;
    dec_ctrl_t  ctrl_q, ctrl_d;

    // Controls are registered from the next-state decode so they line up with state_q.
    function automatic dec_ctrl_t decode(input dec_state_e st, input opcode op,
                                         input logic [3:0] rnd);
        dec_ctrl_t c;
        c = '0;
        case (st)
            KEY_SUB: begin c.busy = 1'b1; c.en_key = 1'b1; c.key_sub = 1'b1; end
            KEY_GEN: begin c.busy = 1'b1; c.en_key = 1'b1; c.gen_key = 1'b1; end
            INIT:    begin
                c.busy = 1'b1; c.en_rnd = 1'b1; c.first_rnd = 1'b1; c.key_sel = 1'b1;
            end
            INV_SBOX: begin
                c.busy = 1'b1; c.en_rnd = 1'b1; c.data_sub = 1'b1;
                if (op == AESDECFULL) begin
                    c.en_key = 1'b1; c.key_sub = 1'b1; c.inv_key = 1'b1;
                end
            end
            ROUND: begin
                c.busy = 1'b1; c.en_rnd = 1'b1;
                case (op)
                    AESDEC:     c.inv_mix = 1'b1;
                    AESIMC:     begin c.imc = 1'b1; c.inv_mix = 1'b1; end
                    AESDECFULL: begin
                        c.en_key  = 1'b1; c.gen_key = 1'b1; c.inv_key = 1'b1;
                        c.key_sel = 1'b1; c.inv_mix = (rnd != 4'd1);
                    end
                    default: ;
                endcase
            end
            FINISH:  c.plain_ready = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    aes_rcon_step u_rcon_step (
        .rcon_i (rcon_q),
        .inv_i  (ctrl_q.inv_key),
        .rcon_o (rcon_step)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rnd_d   = rnd_q;
        rcon_d  = rcon_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    case (opcode_i)
                        AESDEC, AESDECLAST: begin op_d = opcode_i; state_d = INV_SBOX; end
                        AESIMC:             begin op_d = opcode_i; state_d = ROUND;    end
                        AESDECFULL: begin
                            op_d    = opcode_i;
                            state_d = KEY_SUB;
                            rnd_d   = 4'd0;
                            rcon_d  = RCON_FIRST;
                        end
                        default: op_d = NOOP;
                    endcase
                end
            end
            KEY_SUB: state_d = KEY_GEN;
            KEY_GEN: begin
                rnd_d   = rnd_q + 4'd1;
                rcon_d  = rcon_step;
                state_d = (rnd_q == RND_LAST_FWD) ? INIT : KEY_SUB;
            end
            INIT: begin
                rcon_d  = RCON_LAST;
                state_d = INV_SBOX;
            end
            INV_SBOX: state_d = ROUND;
            ROUND: begin
                if (op_q == AESDECFULL) begin
                    rnd_d   = rnd_q - 4'd1;
                    rcon_d  = rcon_step;
                    state_d = (rnd_q == 4'd1) ? FINISH : INV_SBOX;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                rcon_d  = RCON_FIRST;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ctrl_d = decode(state_d, op_d, rnd_d);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            op_q    <= NOOP;
            rnd_q   <= 4'd0;
            rcon_q  <= RCON_FIRST;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rnd_q   <= rnd_d;
            rcon_q  <= rcon_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign data_sub_o    = ctrl_q.data_sub;
    assign first_rnd_o   = ctrl_q.first_rnd;
    assign inv_mix_o     = ctrl_q.inv_mix;
    assign imc_o         = ctrl_q.imc;
    assign key_sel_o     = ctrl_q.key_sel;
    assign en_rnd_o      = ctrl_q.en_rnd;
    assign en_key_o      = ctrl_q.en_key;
    assign key_sub_o     = ctrl_q.key_sub;
    assign gen_key_o     = ctrl_q.gen_key;
    assign inv_key_o     = ctrl_q.inv_key;
    assign plain_ready_o = ctrl_q.plain_ready;
    assign busy_o        = ctrl_q.busy;
    assign rnd_num_o     = rnd_q;
    assign r_con_ctrl_o  = {rcon_q, 24'h000000};

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Randomized bench for aes_dec_ctrl: per-cycle output traces from an operation-level model.
module tb_aes_dec_ctrl;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start_i = 1'b0;
    opcode      opcode_i = NOOP;
    logic       data_sub_o, first_rnd_o, inv_mix_o, imc_o, key_sel_o;
    logic       en_rnd_o, en_key_o, key_sub_o, gen_key_o, inv_key_o;
    logic [3:0] rnd_num_o;
    aes_32      r_con_ctrl_o;
    logic       plain_ready_o, busy_o;

    aes_dec_ctrl #(.NR(10)) dut (
        .clk (clk), .nrst (nrst), .start_i (start_i), .opcode_i (opcode_i),
        .data_sub_o (data_sub_o), .first_rnd_o (first_rnd_o), .inv_mix_o (inv_mix_o),
        .imc_o (imc_o), .key_sel_o (key_sel_o), .en_rnd_o (en_rnd_o), .en_key_o (en_key_o),
        .key_sub_o (key_sub_o), .gen_key_o (gen_key_o), .inv_key_o (inv_key_o),
        .rnd_num_o (rnd_num_o), .r_con_ctrl_o (r_con_ctrl_o),
        .plain_ready_o (plain_ready_o), .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    // Control-bit positions inside the 12-bit field of a trace word.
    localparam logic [11:0] DS  = 12'h800, FR  = 12'h400, IM  = 12'h200, IMC = 12'h100;
    localparam logic [11:0] KS  = 12'h080, ER  = 12'h040, EK  = 12'h020, KSB = 12'h010;
    localparam logic [11:0] GK  = 12'h008, IK  = 12'h004, RDY = 12'h002, BSY = 12'h001;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  fwd [0:10];
    logic [47:0] exp_q [$];
    logic [47:0] idle_vec;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] vec(input logic [11:0] ctl, input int rnd,
                                        input logic [7:0] rc);
        return {ctl, 4'(rnd), rc, 24'h000000};
    endfunction

    function automatic logic [47:0] sample();
        return {data_sub_o, first_rnd_o, inv_mix_o, imc_o, key_sel_o, en_rnd_o, en_key_o,
                key_sub_o, gen_key_o, inv_key_o, plain_ready_o, busy_o, rnd_num_o, r_con_ctrl_o};
    endfunction

    // Expected outputs for each cycle after the start-accept edge; ready is the last entry,
    // so the trace length is the latency in cycles.
    task automatic build_trace(input logic [2:0] op);
        exp_q.delete();
        case (op)
            3'd1, 3'd2: begin
                exp_q.push_back(vec(BSY | ER | DS, 0, 8'h01));
                exp_q.push_back(vec(BSY | ER | ((op == 3'd1) ? IM : 12'h000), 0, 8'h01));
                exp_q.push_back(vec(RDY, 0, 8'h01));
            end
            3'd4: begin
                exp_q.push_back(vec(BSY | ER | IMC | IM, 0, 8'h01));
                exp_q.push_back(vec(RDY, 0, 8'h01));
            end
            3'd3: begin
                for (int r = 0; r < 10; r++) begin
                    exp_q.push_back(vec(BSY | EK | KSB, r, fwd[r]));
                    exp_q.push_back(vec(BSY | EK | GK, r, fwd[r]));
                end
                exp_q.push_back(vec(BSY | ER | FR | KS, 10, fwd[10]));
                for (int r = 10; r >= 1; r--) begin
                    exp_q.push_back(vec(BSY | ER | DS | EK | KSB | IK, r, fwd[r-1]));
                    exp_q.push_back(vec(BSY | ER | EK | GK | IK | KS | ((r != 1) ? IM : 12'h000),
                                        r, fwd[r-1]));
                end
                // rnd has counted down to 0; rcon took one inverse step past 01
                exp_q.push_back(vec(RDY, 0, 8'h00));
            end
            default: ;
        endcase
    endtask

    // Called and returns just after a rising edge.
    task automatic run_op(input int txn, input logic [2:0] op, input int poke_pct);
        int          first_ready;
        logic [47:0] obs;
        start_i  = 1'b1;
        opcode_i = opcode'(op);
        build_trace(op);
        @(posedge clk); #1;
        start_i     = 1'b0;
        first_ready = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            obs = sample();
            check($sformatf("txn%0d op%0d cyc%0d", txn, op, k + 1), obs, exp_q[k]);
            if (obs[37] && first_ready == 0) first_ready = k + 1;
            if (int'($urandom_range(0, 99)) < poke_pct) begin
                start_i  = 1'b1;
                opcode_i = opcode'(3'($urandom_range(0, 7)));
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        if (exp_q.size() > 0)
            check($sformatf("txn%0d op%0d latency", txn, op), 48'(first_ready), 48'(exp_q.size()));
        check($sformatf("txn%0d op%0d idle", txn, op), sample(), idle_vec);
        $display("txn %0d: op=%0d cycles=%0d pokes=%0d%%", txn, op, exp_q.size(), poke_pct);
    endtask

    initial begin
        fwd[0] = 8'h01;
        for (int i = 0; i < 10; i++)
            fwd[i+1] = fwd[i][7] ? ((fwd[i] << 1) ^ 8'h1b) : (fwd[i] << 1);
        idle_vec = vec(12'h000, 0, 8'h01);

        #12;
        check("reset", sample(), idle_vec);
        nrst = 1'b1;
        @(posedge clk); #1;
        check("post_reset", sample(), idle_vec);

        run_op(0, 3'd1, 0);
        run_op(1, 3'd2, 0);
        run_op(2, 3'd4, 0);
        run_op(3, 3'd3, 0);
        run_op(4, 3'd0, 0);
        run_op(5, 3'd6, 0);
        run_op(6, 3'd1, 40);
        run_op(7, 3'd3, 40);
        run_op(8, 3'd4, 100);

        // Abort a full decryption with reset at cycle 25
        start_i  = 1'b1;
        opcode_i = AESDECFULL;
        build_trace(3'd3);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 0; k < 24; k++) begin
            check($sformatf("abort cyc%0d", k + 1), sample(), exp_q[k]);
            @(posedge clk); #1;
        end
        nrst = 1'b0;
        #1;
        check("abort_async", sample(), idle_vec);
        @(posedge clk); #1;
        check("abort_hold", sample(), idle_vec);
        #2 nrst = 1'b1;
        @(posedge clk); #1;
        check("abort_release", sample(), idle_vec);
        $display("txn abort: reset mid AESDECFULL");

        for (int t = 0; t < 25; t++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                check($sformatf("gap%0d", t), sample(), idle_vec);
            end
            run_op(10 + t, 3'($urandom_range(0, 7)), int'($urandom_range(0, 50)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
